cpu_step_ctrl: RTL and testbench

Run/halt/single-step controller that sits directly downstream of the clock prescaler. It consumes the prescaler's one-cycle clock-enable tick and produces the qualified `o_cpu_en` that gates every state element of the single-cycle MIPS core. It is driven by a small command interface (RUN, HALT, STEP N) and an optional PC breakpoint. It also keeps a retired-instruction counter.

---
 rtl/cpu_step_ctrl.sv | 148 ++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl
// Run/halt/single-step controller for the single-cycle core. It qualifies the
// prescaler tick into o_cpu_en, accepts RUN/HALT/STEP commands, optionally
// stops on a PC breakpoint and counts retired instructions.
//
// Build option: define CPU_STEP_CTRL_BREAKPOINT_EN to implement the PC
// breakpoint comparator, skip flag and sticky o_bp_hit. Without it the
// breakpoint inputs are ignored and o_bp_hit is tied low.
//
// Ports:
//   i_clk, i_arst        clock, asynchronous active-high reset
//   i_tick               one-cycle clock-enable pulse from the prescaler
//   i_cmd_valid, i_cmd   command request (00 NOP, 01 RUN, 10 HALT, 11 STEP)
//   i_step_n             instruction count for STEP (0 behaves as 1)
//   o_cmd_ready          command accepted when i_cmd_valid & o_cmd_ready at posedge
//   i_pc                 current core PC
//   i_bp_en, i_bp_addr   breakpoint enable and address
//   o_cpu_en             core advances one instruction this cycle
//   o_state              00 HALT, 01 RUN, 10 STEP
//   o_halted             o_state == HALT
//   o_bp_hit             sticky: a breakpoint stopped execution
//   o_retired            count of o_cpu_en pulses, wraps
module cpu_step_ctrl #(
    parameter int PC_W   = 32,
    parameter int STEP_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_tick,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    input  logic [STEP_W-1:0] i_step_n,
    output logic              o_cmd_ready,
    input  logic [PC_W-1:0]   i_pc,
    input  logic              i_bp_en,
    input  logic [PC_W-1:0]   i_bp_addr,
    output logic              o_cpu_en,
    output logic [1:0]        o_state,
    output logic              o_halted,
    output logic              o_bp_hit,
    output logic [CNT_W-1:0]  o_retired
);
    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_HALT = 2'b10;
    localparam logic [1:0] CMD_STEP = 2'b11;

    state_t            state;
    logic [STEP_W-1:0] remaining;
    logic [CNT_W-1:0]  retired;
    logic              match;
    logic              active_tick;
    logic              cmd_accept;

    // Command handshake: a command transfers on a posedge where both
    // i_cmd_valid and o_cmd_ready are high. The requester may hold valid for
    // any number of cycles; ready is low only while a STEP is in progress,
    // so a STEP can be ended only by completion, a breakpoint or reset.
    assign o_cmd_ready = (state != ST_STEP);
    assign cmd_accept  = i_cmd_valid & o_cmd_ready;
    assign o_halted    = (state == ST_HALT);
    assign o_state     = state;
    assign o_retired   = retired;

    // Tick seen while executing; the breakpoint may still veto the pulse.
    assign active_tick = i_tick & (state != ST_HALT);
    assign o_cpu_en    = active_tick & ~match;

`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    logic skip;
    logic bp_hit;

    // skip masks the comparator for the first tick after RUN/STEP so that
    // resuming while parked on the breakpoint PC executes that instruction.
    assign match    = i_bp_en & (i_pc == i_bp_addr) & ~skip;
    assign o_bp_hit = bp_hit;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            skip   <= 1'b0;
            bp_hit <= 1'b0;
        end else begin
            if (active_tick) begin
                skip <= 1'b0;
                if (match) begin
                    bp_hit <= 1'b1;
                end
            end
            // A command in the same cycle takes priority over the tick.
            if (cmd_accept) begin
                bp_hit <= 1'b0;
                if (i_cmd == CMD_RUN || i_cmd == CMD_STEP) begin
                    skip <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_bp;
    assign unused_bp = ^{i_pc, i_bp_en, i_bp_addr};
    assign match     = 1'b0;
    assign o_bp_hit  = 1'b0;
`endif

    // Tick effects are computed from the state in force this cycle; an
    // accepted command then overrides the next state, so a HALT issued
    // together with a tick still lets that tick retire.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state     <= ST_HALT;
            remaining <= '0;
            retired   <= '0;
        end else begin
            if (active_tick) begin
                if (match) begin
                    // Breakpoint wins over a final step; the leftover count
                    // is harmless because HALT ignores it.
                    state <= ST_HALT;
                end else begin
                    retired <= retired + CNT_W'(1);
                    if (state == ST_STEP) begin
                        remaining <= remaining - STEP_W'(1);
                        if (remaining == STEP_W'(1)) begin
                            state <= ST_HALT;
                        end
                    end
                end
            end
            if (cmd_accept) begin
                case (i_cmd)
                    CMD_RUN:  state <= ST_RUN;
                    CMD_HALT: state <= ST_HALT;
                    CMD_STEP: begin
                        state     <= ST_STEP;
                        remaining <= (i_step_n == '0) ? STEP_W'(1) : i_step_n;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl: directed vector table, hand-written corner
// sequences and random stimulus checked against a behavioural model.
module tb_cpu_step_ctrl;
    localparam int PC_W   = 32;
    localparam int STEP_W = 8;
    localparam int CNT_W  = 4;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    localparam bit BP_ON = 1'b1;
`else
    localparam bit BP_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic              i_clk = 1'b0;
    logic              i_arst;
    logic              i_tick;
    logic              i_cmd_valid;
    logic [1:0]        i_cmd;
    logic [STEP_W-1:0] i_step_n;
    logic              o_cmd_ready;
    logic [PC_W-1:0]   i_pc;
    logic              i_bp_en;
    logic [PC_W-1:0]   i_bp_addr;
    logic              o_cpu_en;
    logic [1:0]        o_state;
    logic              o_halted;
    logic              o_bp_hit;
    logic [CNT_W-1:0]  o_retired;

    always #5 i_clk = ~i_clk;

    cpu_step_ctrl #(.PC_W(PC_W), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_tick(i_tick),
        .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .i_step_n(i_step_n),
        .o_cmd_ready(o_cmd_ready), .i_pc(i_pc), .i_bp_en(i_bp_en),
        .i_bp_addr(i_bp_addr), .o_cpu_en(o_cpu_en), .o_state(o_state),
        .o_halted(o_halted), .o_bp_hit(o_bp_hit), .o_retired(o_retired)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    int pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Mode: 0 halted, 1 running, 2 stepping (same numbering as o_state).
    int         m_mode;
    int         m_budget;   // instructions left in the current STEP
    logic [3:0] m_ret;      // modulo-16 instruction count
    bit         m_hit;
    bit         m_resume;   // first tick after RUN/STEP ignores the breakpoint

    task automatic model_reset();
        m_mode = 0; m_budget = 0; m_ret = '0; m_hit = 0; m_resume = 0;
    endtask

    // Check current outputs against the model, then advance the model and
    // the clock by one cycle.
    task automatic finish_cycle();
        bit at_bp, exp_en, exp_rdy;
        at_bp   = BP_ON && i_bp_en && (i_pc == i_bp_addr) && !m_resume;
        exp_en  = i_tick && (m_mode != 0) && !at_bp;
        exp_rdy = (m_mode != 2);
        chk("cpu_en", 32'(o_cpu_en), 32'(exp_en));
        chk("cmd_ready", 32'(o_cmd_ready), 32'(exp_rdy));
        chk("halted", 32'(o_halted), 32'(m_mode == 0));
        chk("state", 32'(o_state), 32'(m_mode));
        chk("retired", 32'(o_retired), 32'(m_ret));
        chk("bp_hit", 32'(o_bp_hit), 32'(m_hit));
        if (o_cpu_en) pulses++;
        if (i_tick && m_mode != 0) begin
            m_resume = 0;
            if (at_bp) begin
                m_mode = 0;
                m_hit  = 1;
            end else begin
                m_ret = m_ret + 4'd1;
                if (m_mode == 2) begin
                    m_budget = m_budget - 1;
                    if (m_budget == 0) m_mode = 0;
                end
            end
        end
        if (i_cmd_valid && exp_rdy) begin
            m_hit = 0;
            case (i_cmd)
                2'b01: begin m_mode = 1; m_resume = 1; end
                2'b10: m_mode = 0;
                2'b11: begin
                    m_mode   = 2;
                    m_resume = 1;
                    m_budget = (i_step_n == 0) ? 1 : int'(i_step_n);
                end
                default: ;
            endcase
        end
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit t, input bit v, input logic [1:0] c,
                         input logic [7:0] n, input logic [31:0] pc);
        i_tick = t; i_cmd_valid = v; i_cmd = c; i_step_n = n; i_pc = pc;
        #3;
    endtask

    task automatic cyc(input bit t, input bit v, input logic [1:0] c,
                       input logic [7:0] n, input logic [31:0] pc);
        drive(t, v, c, n, pc);
        finish_cycle();
    endtask

    // Asynchronous reset asserted in the middle of a cycle.
    task automatic async_reset(input bit t);
        i_tick = t; i_cmd_valid = 1'b0;
        #2;
        i_arst = 1'b1;
        #1;
        chk("rst_cpu_en", 32'(o_cpu_en), 32'd0);
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_retired", 32'(o_retired), 32'd0);
        chk("rst_ready", 32'(o_cmd_ready), 32'd1);
        chk("rst_bp_hit", 32'(o_bp_hit), 32'd0);
        #2;
        i_arst = 1'b0;
        i_tick = 1'b0;
        model_reset();
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         t;
        bit         v;
        logic [1:0] c;
        logic [7:0] n;
        bit         e_en;
        logic [1:0] e_st;
        bit         e_rdy;
        logic [3:0] e_ret;
    } vec_t;

    vec_t vecs[20];

    initial begin
        //           tick vld cmd    n     en st     rdy ret
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1, 4'd0};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1, 4'd0};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1, 4'd0};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1, 4'd0};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 2'd1, 8'd0, 1'b0, 2'd0, 1'b1, 4'd0};
        vecs[6]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 2'd1, 1'b1, 4'd0};
        vecs[7]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 2'd1, 1'b1, 4'd1};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd1, 1'b1, 4'd2};
        vecs[9]  = '{1'b1, 1'b1, 2'd2, 8'd0, 1'b1, 2'd1, 1'b1, 4'd2};
        vecs[10] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1, 4'd3};
        vecs[11] = '{1'b0, 1'b1, 2'd3, 8'd3, 1'b0, 2'd0, 1'b1, 4'd3};
        vecs[12] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 1'b0, 4'd3};
        vecs[13] = '{1'b0, 1'b1, 2'd1, 8'd0, 1'b0, 2'd2, 1'b0, 4'd4};
        vecs[14] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 1'b0, 4'd4};
        vecs[15] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 1'b0, 4'd5};
        vecs[16] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1, 4'd6};
        vecs[17] = '{1'b0, 1'b1, 2'd3, 8'd0, 1'b0, 2'd0, 1'b1, 4'd6};
        vecs[18] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 1'b0, 4'd6};
        vecs[19] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1, 4'd7};

        // -------- reset state --------
        i_arst = 1'b1; i_tick = 1'b0; i_cmd_valid = 1'b0; i_cmd = 2'd0;
        i_step_n = '0; i_pc = '0; i_bp_en = 1'b0; i_bp_addr = 32'h40;
        model_reset();
        #3;
        chk("reset_halted", 32'(o_halted), 32'd1);
        chk("reset_state", 32'(o_state), 32'd0);
        chk("reset_cpu_en", 32'(o_cpu_en), 32'd0);
        chk("reset_retired", 32'(o_retired), 32'd0);
        chk("reset_ready", 32'(o_cmd_ready), 32'd1);
        chk("reset_bp_hit", 32'(o_bp_hit), 32'd0);
        #4;
        i_arst = 1'b0;
        @(posedge i_clk);
        #1;

        // -------- table-driven vectors --------
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].t, vecs[i].v, vecs[i].c, vecs[i].n, 32'h0);
            chk($sformatf("vec%0d_en", i), 32'(o_cpu_en), 32'(vecs[i].e_en));
            chk($sformatf("vec%0d_state", i), 32'(o_state), 32'(vecs[i].e_st));
            chk($sformatf("vec%0d_ready", i), 32'(o_cmd_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_retired", i), 32'(o_retired), 32'(vecs[i].e_ret));
            finish_cycle();
        end

        // -------- RUN, 10 ticks, HALT coincident with the 10th tick --------
        cyc(0, 1, 2'd1, 8'd0, 32'h0);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 2'd0, 8'd0, 32'h0);
            cyc(0, 0, 2'd0, 8'd0, 32'h0);
        end
        cyc(1, 1, 2'd2, 8'd0, 32'h0);
        chk("run10_pulses", 32'(pulses), 32'd10);
        chk("run10_retired", 32'(o_retired), 32'(4'(7 + 10)));
        chk("run10_halted", 32'(o_halted), 32'd1);
        cyc(1, 0, 2'd0, 8'd0, 32'h0);

        // -------- breakpoint sequences --------
        async_reset(1'b0);
        i_bp_en = 1'b1; i_bp_addr = 32'h40;
        cyc(0, 1, 2'd1, 8'd0, 32'h3c);
        cyc(1, 0, 2'd0, 8'd0, 32'h3c);
        drive(1, 0, 2'd0, 8'd0, 32'h40);
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
        chk("bp_block", 32'(o_cpu_en), 32'd0);
`endif
        finish_cycle();
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
        chk("bp_hit_set", 32'(o_bp_hit), 32'd1);
        chk("bp_halted", 32'(o_halted), 32'd1);
`endif
        cyc(0, 1, 2'd1, 8'd0, 32'h40);
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
        chk("bp_hit_clear", 32'(o_bp_hit), 32'd0);
`endif
        drive(1, 0, 2'd0, 8'd0, 32'h40);
        chk("bp_resume_pulse", 32'(o_cpu_en), 32'd1);
        finish_cycle();
        cyc(1, 0, 2'd0, 8'd0, 32'h44);
        drive(1, 0, 2'd0, 8'd0, 32'h40);
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
        chk("bp_rehit", 32'(o_cpu_en), 32'd0);
`endif
        finish_cycle();
        // STEP 2 whose final tick lands on the breakpoint: match wins.
        cyc(0, 1, 2'd3, 8'd2, 32'h40);
        cyc(1, 0, 2'd0, 8'd0, 32'h3c);
        drive(1, 0, 2'd0, 8'd0, 32'h40);
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
        chk("bp_last_step_block", 32'(o_cpu_en), 32'd0);
`endif
        finish_cycle();
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
        chk("bp_last_step_hit", 32'(o_bp_hit), 32'd1);
`endif
        chk("bp_last_step_halted", 32'(o_halted), 32'd1);

        // -------- random stimulus against the model --------
        for (int i = 0; i < 400; i++) begin
            bit         t, v;
            logic [1:0] c;
            logic [7:0] n;
            logic [31:0] pc;
            t  = ($urandom_range(0, 2) == 0);
            v  = ($urandom_range(0, 5) == 0);
            if (v) t = 1'b0;
            c  = 2'($urandom_range(0, 3));
            n  = 8'($urandom_range(0, 5));
            pc = 32'h3c + 32'(4 * $urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) i_bp_en = 1'($urandom_range(0, 1));
            cyc(t, v, c, n, pc);
        end

        // -------- reset in the middle of STEP 200 --------
        async_reset(1'b0);
        i_bp_en = 1'b0;
        cyc(0, 1, 2'd3, 8'd200, 32'h0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 2'd0, 8'd0, 32'h0);
        async_reset(1'b1);
        cyc(1, 0, 2'd0, 8'd0, 32'h0);

        // -------- retired counter wrap --------
        cyc(0, 1, 2'd1, 8'd0, 32'h0);
        for (int i = 0; i < 15; i++) cyc(1, 0, 2'd0, 8'd0, 32'h0);
        chk("wrap_preload", 32'(o_retired), 32'd15);
        cyc(1, 0, 2'd0, 8'd0, 32'h0);
        chk("wrap_zero", 32'(o_retired), 32'd0);
        cyc(0, 1, 2'd2, 8'd0, 32'h0);
        cyc(1, 0, 2'd0, 8'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
